// File: rtl/val_shift_engine.sv
// val_shift_engine: multi-cycle ARM-style shifter-operand unit.
// A request is decoded into an operand, a shift type and an effective count.
// The engine then shifts the operand by at most STEP bits per cycle until the
// count is used up. The result is held until the consumer takes it.
module val_shift_engine #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rm,
  input  logic [7:0]       rs,
  input  logic [11:0]      shift_op,
  input  logic             imm,
  input  logic             mem_cmd,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val2,
  output logic             c_out
);

  // The count can reach WIDTH+1 because LSL/LSR saturate one step past the width.
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] work;
  logic [1:0]       work_type;
  logic [CW-1:0]    remaining;

  logic [WIDTH-1:0] dec_operand;
  logic [1:0]       dec_type;
  logic [CW-1:0]    dec_count;
  logic             dec_carry;
  logic [7:0]       amount;

  logic [CW-1:0]    step;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] step_result;
  logic             step_carry;

  // Decode a request into operand, shift type, effective count and zero-count carry.
  always_comb begin
    dec_operand = rm;
    dec_type    = shift_op[6:5];
    dec_count   = '0;
    dec_carry   = c_in;
    amount      = '0;
    if (mem_cmd) begin
      dec_operand = {{(WIDTH-12){shift_op[11]}}, shift_op};
    end else if (imm) begin
      dec_operand = {{(WIDTH-8){1'b0}}, shift_op[7:0]};
      dec_type    = 2'b11;
      amount      = {3'b000, shift_op[11:8], 1'b0};
    end else begin
      amount = shift_op[4] ? rs : {3'b000, shift_op[11:7]};
    end
    if (!mem_cmd && amount != 8'd0) begin
      case (dec_type)
        2'b00, 2'b01: dec_count = (int'(amount) > WIDTH + 1) ? CW'(WIDTH + 1) : CW'(amount);
        2'b10:        dec_count = (int'(amount) > WIDTH) ? CW'(WIDTH) : CW'(amount);
        default: begin
          // A rotate by a nonzero multiple of WIDTH leaves the operand alone but
          // still reports its top bit as the carry.
          dec_count = CW'(int'(amount) % WIDTH);
          if (dec_count == '0) dec_carry = dec_operand[WIDTH-1];
        end
      endcase
    end
  end

  // One shifting step of up to STEP bits, also producing the last bit shifted out.
  always_comb begin
    step        = (int'(remaining) > STEP) ? CW'(STEP) : remaining;
    ext         = '0;
    step_result = work;
    step_carry  = 1'b0;
    case (work_type)
      2'b00: begin
        ext         = {1'b0, work} << step;
        step_result = ext[WIDTH-1:0];
        step_carry  = ext[WIDTH];
      end
      2'b01: begin
        ext         = {work, 1'b0} >> step;
        step_result = ext[WIDTH:1];
        step_carry  = ext[0];
      end
      2'b10: begin
        ext         = $unsigned($signed({work, 1'b0}) >>> step);
        step_result = ext[WIDTH:1];
        step_carry  = ext[0];
      end
      default: begin
        step_result = (work >> step) | (work << (CW'(WIDTH) - step));
        step_carry  = step_result[WIDTH-1];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: skip SHIFT for zero counts, leave DONE only when the result is taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = (dec_count == '0) ? DONE : SHIFT;
      SHIFT:   if (int'(remaining) <= STEP) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs follow directly from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: load on accept, shift while busy, publish the result only on entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      work_type <= '0;
      remaining <= '0;
      val2      <= '0;
      c_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= dec_operand;
            work_type <= dec_type;
            remaining <= dec_count;
            if (dec_count == '0) begin
              val2  <= dec_operand;
              c_out <= dec_carry;
            end
          end
        end
        SHIFT: begin
          work      <= step_result;
          remaining <= remaining - step;
          if (remaining == step) begin
            val2  <= step_result;
            c_out <= step_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_val_shift_engine.sv
// Directed testbench for val_shift_engine at WIDTH=32, STEP=8.
module tb_val_shift_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rm;
  logic [7:0]  rs;
  logic [11:0] shift_op;
  logic        imm;
  logic        mem_cmd;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;
  logic        c_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  val_shift_engine #(.WIDTH(32), .STEP(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rm(rm), .rs(rs), .shift_op(shift_op), .imm(imm), .mem_cmd(mem_cmd),
    .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .val2(val2), .c_out(c_out)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request, wait for its accept edge, then count cycles until out_valid.
  task automatic applyStimulus(input string tag, input logic [31:0] r, input logic [7:0] s,
                               input logic [11:0] op, input logic im, input logic mc,
                               input logic ci, output int lat);
    @(negedge clk);
    checkOutput({tag, "/ready"}, {31'd0, in_ready}, 32'd1);
    rm = r; rs = s; shift_op = op; imm = im; mem_cmd = mc; c_in = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  // Hand the result to the consumer and confirm the engine is idle afterwards.
  task automatic releaseResult(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput({tag, "/idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Full directed vector: request, result, carry and latency checks, then release.
  task automatic runVector(input string tag, input logic [31:0] r, input logic [7:0] s,
                           input logic [11:0] op, input logic im, input logic mc, input logic ci,
                           input logic [31:0] expVal, input logic expC, input int expLat);
    int lat;
    applyStimulus(tag, r, s, op, im, mc, ci, lat);
    checkOutput({tag, "/val2"}, val2, expVal);
    checkOutput({tag, "/c_out"}, {31'd0, c_out}, {31'd0, expC});
    checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
    releaseResult(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rm = '0; rs = '0; shift_op = '0; imm = 1'b0; mem_cmd = 1'b0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset/in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset/out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset/val2", val2, 32'd0);
    checkOutput("reset/c_out", {31'd0, c_out}, 32'd0);
    rst = 1'b0;

    //        tag         rm            rs     shift_op imm mem c_in  val2          c  lat
    runVector("imm_ror8", 32'h0,        8'd0,  12'h4FF, 1, 0, 0, 32'hFF000000, 1, 2);
    runVector("mem_neg",  32'h0,        8'd0,  12'hF9C, 0, 1, 0, 32'hFFFFFF9C, 0, 1);
    runVector("asr4",     32'h80000010, 8'd0,  12'h240, 0, 0, 1, 32'hF8000001, 0, 2);
    runVector("lsl_r32",  32'h1,        8'd32, 12'h010, 0, 0, 0, 32'h0,        1, 5);
    runVector("lsl_r33",  32'h1,        8'd33, 12'h010, 0, 0, 1, 32'h0,        0, 6);
    runVector("ror_r32",  32'h80000001, 8'd32, 12'h070, 0, 0, 0, 32'h80000001, 1, 1);
    runVector("ror_r0",   32'h12345678, 8'd0,  12'h070, 0, 0, 1, 32'h12345678, 1, 1);
    runVector("lsr1",     32'h3,        8'd0,  12'h0A0, 0, 0, 0, 32'h1,        1, 2);
    runVector("asr_r40",  32'h80000000, 8'd40, 12'h050, 0, 0, 0, 32'hFFFFFFFF, 1, 5);
    runVector("lsr_r32",  32'h80000000, 8'd32, 12'h030, 0, 0, 0, 32'h0,        1, 5);
    runVector("lsl0",     32'hA5A5A5A5, 8'd0,  12'h000, 0, 0, 1, 32'hA5A5A5A5, 1, 1);
    runVector("lsl_r9",   32'h00800001, 8'd9,  12'h010, 0, 0, 0, 32'h00000200, 1, 3);
    runVector("imm_rot0", 32'h0,        8'd0,  12'h0AB, 1, 0, 1, 32'h000000AB, 1, 1);

    // Result must hold for several cycles without out_ready, ignoring new requests.
    applyStimulus("hold", 32'h12345678, 8'd12, 12'h070, 1'b0, 1'b0, 1'b0, lat);
    checkOutput("hold/val2", val2, 32'h67812345);
    checkOutput("hold/c_out", {31'd0, c_out}, 32'd0);
    checkOutput("hold/latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; mem_cmd = 1'b1; shift_op = 12'h123;
      checkOutput("hold/stable", val2, 32'h67812345);
      checkOutput("hold/out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold/in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; mem_cmd = 1'b0;
    releaseResult("hold");

    // Reset in the middle of a long shift.
    @(negedge clk);
    rm = 32'h1; rs = 8'd33; shift_op = 12'h010; imm = 1'b0; mem_cmd = 1'b0; c_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid/out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid/in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mid/val2", val2, 32'd0);
    checkOutput("rst_mid/c_out", {31'd0, c_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runVector("post_rst", 32'h0, 8'd0, 12'hF9C, 0, 1, 0, 32'hFFFFFF9C, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/val_shift_engine.md
VAL_SHIFT_ENGINE -- requirements
Module: val_shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (power of two, >=16).
REQ-002 SHALL have parameter STEP, default 8, max bits shifted per cycle (1..WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  engine idle, can accept a request.
REQ-007 SHALL have port rm  input  WIDTH  operand to shift.
REQ-008 SHALL have port rs  input  8  register shift amount (rs[7:0]).
REQ-009 SHALL have port shift_op  input  12  ARM shifter-operand field.
REQ-010 SHALL have port imm  input  1  immediate-rotate mode.
REQ-011 SHALL have port mem_cmd  input  1  memory-offset mode.
REQ-012 SHALL have port c_in  input  1  carry flag in.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer takes result.
REQ-015 SHALL have port val2  output  WIDTH  result operand.
REQ-016 SHALL have port c_out  output  1  shifter carry out.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, registering all inputs; in_valid outside IDLE SHALL be ignored.
REQ-019 Mode priority SHALL be mem_cmd > imm > shift; mem_cmd: val2 = shift_op sign-extended from bit 11, c_out=c_in, effective count 0.
REQ-020 imm mode: operand = zero-extended shift_op[7:0], ROR by 2*shift_op[11:8].
REQ-021 Shift mode: type = shift_op[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); amount = shift_op[11:7] if shift_op[4]=0, else rs[7:0].
REQ-022 Effective count: LSL/LSR min(amount, WIDTH+1); ASR min(amount, WIDTH); ROR amount mod WIDTH.
REQ-023 Amount 0 (any type, any mode) SHALL yield val2=operand, c_out=c_in.
REQ-024 ROR with nonzero amount and amount mod WIDTH = 0 SHALL yield val2=rm, c_out=rm[WIDTH-1], count 0.
REQ-025 c_out SHALL equal the last bit shifted out; for ROR/imm rotate with nonzero count, c_out = val2[WIDTH-1].
REQ-026 On accept, count 0 SHALL go to DONE; otherwise SHIFT with remaining=count.
REQ-027 Each SHIFT cycle SHALL shift by min(STEP, remaining) and decrement; when remaining reaches 0, go to DONE.
REQ-028 out_valid SHALL rise exactly 1+ceil(count/STEP) cycles after the accept edge.
REQ-029 In DONE, out_valid=1 and val2/c_out SHALL hold stable until an edge with out_ready=1, then go to IDLE (in_ready=1 next cycle; no same-cycle re-accept).
REQ-030 val2 and c_out SHALL hold their last values outside DONE.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, out_valid=0, val2=0, c_out=0, remaining=0, in any state including mid-SHIFT.
REQ-032 After rst deassertion, in_ready SHALL be 1 and the first request SHALL behave as from power-up.

Verification (WIDTH=32, STEP=8)
REQ-033 imm=1, shift_op=12'h4FF -> val2=0xFF000000, c_out=1, out_valid 2 cycles after accept.
REQ-034 mem_cmd=1, shift_op=12'hF9C, c_in=0 -> val2=0xFFFFFF9C, c_out=0, out_valid 1 cycle after accept.
REQ-035 rm=0x80000010, ASR #4 (shift_op=12'h240) -> val2=0xF8000001, c_out=0, out_valid 2 cycles after accept.
REQ-036 LSL by register: rs=32, rm=1 -> val2=0, c_out=1; rs=33 -> val2=0, c_out=0, out_valid 6 cycles after accept.
REQ-037 ROR by register rs=32, rm=0x80000001 -> val2=0x80000001, c_out=1, 1-cycle latency; rs=0 -> c_out=c_in.
REQ-038 out_ready=0 for 5 cycles in DONE -> val2 stable, in_valid ignored; rst pulse mid-SHIFT -> out_valid=0, in_ready=1 immediately.
